// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer beside an 8-to-1 mux.
// Drives the mux select through 0..7 and holds each select value for SETTLE cycles.
// Samples mux_out on the last cycle of each step.
// On the completion edge it publishes the assembled 8-bit word on data and pulses done.
// Optional feature macro: SCAN_PARITY_EN. When defined, it adds a registered parity output.
// That output is the XOR of data.
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic [7:0] data,
  output logic       busy,
`ifdef SCAN_PARITY_EN
  output logic       parity,
`endif
  output logic       done
);

  // Last wait count of each select step.
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  // Reject settle times that the 8-bit wait counter cannot represent.
  generate
    if ((SETTLE < 1) || (SETTLE > 255)) begin : g_settle_range_bad
      $error("mux_scan_ctrl: SETTLE must be within 1..255");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  sel_r, sel_s;
  logic [7:0]  wait_r, wait_s;
  logic [7:0]  shreg_r, shreg_s;
  logic [7:0]  data_r, data_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [7:0]  asm_s;

`ifdef SCAN_PARITY_EN
  logic        parity_r, parity_s;

  // Even parity over a captured byte.
  function automatic logic parity8(input logic [7:0] w);
    return ^w;
  endfunction
`endif

  // State and output registers; the async reset aborts any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      sel_r    <= 3'd0;
      wait_r   <= 8'd0;
      shreg_r  <= 8'h00;
      data_r   <= 8'h00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      wait_r   <= wait_s;
      shreg_r  <= shreg_s;
      data_r   <= data_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef SCAN_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  // Next-state logic: step sel, count settle cycles, assemble the word and publish it on completion.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    wait_s   = wait_r;
    shreg_s  = shreg_r;
    data_s   = data_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
`ifdef SCAN_PARITY_EN
    parity_s = parity_r;
`endif
    // Word as it looks once the current mux_out bit is merged in.
    asm_s         = shreg_r;
    asm_s[sel_r]  = mux_out;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
          sel_s   = 3'd0;
          wait_s  = 8'd0;
          shreg_s = 8'h00;
          busy_s  = 1'b1;
        end else begin
          sel_s   = 3'd0;
          busy_s  = 1'b0;
        end
      end
      SCAN: begin
        if (wait_r < SETTLE_M1) begin
          wait_s = wait_r + 8'd1;
        end else begin
          wait_s  = 8'd0;
          shreg_s = asm_s;
          if (sel_r != 3'd7) begin
            sel_s = sel_r + 3'd1;
          end else begin
            // Completion: the bit sampled on this edge is part of the published word.
            data_s   = asm_s;
            done_s   = 1'b1;
            busy_s   = 1'b0;
            sel_s    = 3'd0;
            state_s  = IDLE;
`ifdef SCAN_PARITY_EN
            parity_s = parity8(asm_s);
`endif
          end
        end
      end
      default: begin
        state_s = IDLE;
        sel_s   = 3'd0;
        wait_s  = 8'd0;
        shreg_s = 8'h00;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign sel    = sel_r;
  assign data   = data_r;
  assign busy   = busy_r;
  assign done   = done_r;
`ifdef SCAN_PARITY_EN
  assign parity = parity_r;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) beside behavioural muxes.
// Directed scenarios run first, followed by randomized starts, inputs and resets.
// Every cycle's outputs are compared against a timing model based on edge counts.
module tb_mux_scan_ctrl;

  localparam int SA = 1;
  localparam int SB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] in_a = 8'h00, in_b = 8'h00;
  logic [2:0] sel_a, sel_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       mux_a, mux_b;
`ifdef SCAN_PARITY_EN
  logic       parity_a, parity_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state, index 0 = SETTLE 1 instance, 1 = SETTLE 3 instance.
  int         m_sel  [2];
  int         m_j    [2];
  logic       m_busy [2];
  logic       m_done [2];
  logic [7:0] m_data [2];
  logic [7:0] m_acc  [2];

  always #5 clk = ~clk;

  // Behavioural 8-to-1 muxes.
  assign mux_a = in_a[sel_a];
  assign mux_b = in_b[sel_b];

  mux_scan_ctrl #(.SETTLE(SA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mux_out(mux_a),
    .sel(sel_a), .data(data_a), .busy(busy_a),
`ifdef SCAN_PARITY_EN
    .parity(parity_a),
`endif
    .done(done_a)
  );

  mux_scan_ctrl #(.SETTLE(SB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mux_out(mux_b),
    .sel(sel_b), .data(data_b), .busy(busy_b),
`ifdef SCAN_PARITY_EN
    .parity(parity_b),
`endif
    .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset(input int d);
    m_sel[d]  = 0;
    m_j[d]    = 0;
    m_busy[d] = 1'b0;
    m_done[d] = 1'b0;
    m_data[d] = 8'h00;
    m_acc[d]  = 8'h00;
  endtask

  // One clock edge of the model: j counts edges since the start edge; bit k is taken at j=(k+1)*s.
  task automatic model_step(input int d, input logic r, input logic st, input logic [7:0] inv);
    int s;
    int k;
    s = (d == 0) ? SA : SB;
    if (r) begin
      model_reset(d);
    end else if (!m_busy[d]) begin
      m_done[d] = 1'b0;
      m_sel[d]  = 0;
      if (st) begin
        m_busy[d] = 1'b1;
        m_j[d]    = 0;
      end
    end else begin
      m_done[d] = 1'b0;
      m_j[d]++;
      if ((m_j[d] % s) == 0) begin
        k = m_j[d] / s - 1;
        m_acc[d][k] = inv[k];
      end
      if (m_j[d] == 8 * s) begin
        m_data[d] = m_acc[d];
        m_busy[d] = 1'b0;
        m_done[d] = 1'b1;
        m_sel[d]  = 0;
      end else begin
        m_sel[d] = m_j[d] / s;
      end
    end
  endtask

  task automatic compare_all();
    chk("sel_a",  32'(sel_a),  32'(m_sel[0]));
    chk("busy_a", 32'(busy_a), 32'(m_busy[0]));
    chk("done_a", 32'(done_a), 32'(m_done[0]));
    chk("data_a", 32'(data_a), 32'(m_data[0]));
    chk("sel_b",  32'(sel_b),  32'(m_sel[1]));
    chk("busy_b", 32'(busy_b), 32'(m_busy[1]));
    chk("done_b", 32'(done_b), 32'(m_done[1]));
    chk("data_b", 32'(data_b), 32'(m_data[1]));
`ifdef SCAN_PARITY_EN
    chk("parity_a", 32'(parity_a), 32'(^m_data[0]));
    chk("parity_b", 32'(parity_b), 32'(^m_data[1]));
`endif
  endtask

  // Capture inputs before the edge, advance the model on the edge, compare 1 time unit later.
  task automatic tick();
    logic       r, sa, sb;
    logic [7:0] ia, ib;
    r  = rst;
    sa = start_a;
    sb = start_b;
    ia = in_a;
    ib = in_b;
    @(posedge clk);
    model_step(0, r, sa, ia);
    model_step(1, r, sb, ib);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
  endtask

  initial begin
    int busy_cnt;
    int dcount;
    int first_d;
    int second_d;

    model_reset(0);
    model_reset(1);

    // Asynchronous reset before any clock edge.
    #2;
    async_reset();
    chk("rst_data_a", 32'(data_a), 32'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single scans: A5 with SETTLE=1, 3C with SETTLE=3, started on the same edge.
    in_a = 8'hA5;
    in_b = 8'h3C;
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    busy_cnt = busy_a ? 1 : 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (busy_a) busy_cnt++;
      if (i == 7) chk("a5_early", 32'(done_a), 32'd0);
      if (i == 8) begin
        chk("a5_done", 32'(done_a), 32'd1);
        chk("a5_data", 32'(data_a), 32'hA5);
`ifdef SCAN_PARITY_EN
        chk("a5_par", 32'(parity_a), 32'd0);
`endif
      end
      if (i == 9) chk("a5_done_width", 32'(done_a), 32'd0);
      if (i == 23) begin
        chk("3c_early", 32'(done_b), 32'd0);
        chk("3c_hold", 32'(data_b), 32'h00);
      end
      if (i == 24) begin
        chk("3c_done", 32'(done_b), 32'd1);
        chk("3c_data", 32'(data_b), 32'h3C);
`ifdef SCAN_PARITY_EN
        chk("3c_par", 32'(parity_b), 32'd0);
`endif
      end
    end
    chk("a5_busy_len", 32'(busy_cnt), 32'd8);
    tick();
    tick();

    // Start pulses while busy are ignored.
    in_a = 8'h01;
    start_a = 1'b1;
    tick();
    dcount = 0;
    for (int i = 1; i <= 12; i++) begin
      start_a = ((i == 2) || (i == 5)) ? 1'b1 : 1'b0;
      tick();
      if (done_a) dcount++;
    end
    start_a = 1'b0;
    chk("ign_done_cnt", 32'(dcount), 32'd1);
    chk("ign_data", 32'(data_a), 32'h01);
`ifdef SCAN_PARITY_EN
    chk("ign_par", 32'(parity_a), 32'd1);
`endif

    // Back-to-back scans with start held high.
    in_a = 8'hFF;
    start_a = 1'b1;
    first_d = -1;
    second_d = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_a) begin
        if (first_d < 0) begin
          first_d = cyc;
          chk("b2b_data1", 32'(data_a), 32'hFF);
          in_a = 8'h0F;
        end else if (second_d < 0) begin
          second_d = cyc;
          chk("b2b_data2", 32'(data_a), 32'h0F);
        end
      end
      if (second_d >= 0) break;
    end
    chk("b2b_seen", 32'(second_d >= 0), 32'd1);
    chk("b2b_gap", 32'(second_d - first_d), 32'd9);
    start_a = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Reset in the middle of a scan.
    in_a = 8'h5A;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_sel4", 32'(sel_a), 32'd4);
    async_reset();
    chk("abort_data", 32'(data_a), 32'h00);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_a) dcount++;
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_a) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("restart_data", 32'(data_a), 32'h5A);

    // Randomized starts, inputs and occasional resets.
    for (int i = 0; i < 600; i++) begin
      start_a = ($urandom_range(3) == 0);
      start_b = ($urandom_range(3) == 0);
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      if ($urandom_range(150) == 0) begin
        async_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer placed beside the 8-to-1 multiplexer. It drives the mux select and samples the mux output.
- Steps sel through 0..7 and captures each selected input into an 8-bit parallel word. The result is a registered snapshot of in0..in7 obtained through the mux.
- start/busy/done handshake toward the consuming logic.

Parameters:
SETTLE, 1, clock cycles per select step: mux_out is sampled SETTLE cycles after sel changes; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request one full scan; sampled only in IDLE
mux_out  input  1  output of the 8-to-1 mux; bit k of the result when sel==k
sel  output  3  mux select, registered
data  output  8  captured word: data[k] = mux_out value sampled while sel==k
busy  output  1  high while a scan is in progress
done  output  1  single-cycle pulse, high in the cycle after scan completion

Behaviour:
- Reset: async, active-high; one clock domain, no synchroniser on rst.
  - sel=0, data=8'h00, busy=0, done=0, state=IDLE, wait counter=0, internal shift register=0.
- States: IDLE, SCAN.
- IDLE:
  - done is deasserted on every edge unless a completion occurs on that edge.
  - Edge E0 with start=1 loads sel<=0, wait_cnt<=0, busy<=1 and moves to SCAN.
  - start=0 keeps the block in IDLE with sel=0.
- SCAN:
  - Each edge with wait_cnt<SETTLE-1 increments wait_cnt.
  - The edge with wait_cnt==SETTLE-1 samples mux_out into bit sel of the internal register and clears wait_cnt.
    - sel<7: sel<=sel+1.
    - sel==7: completion edge. data<=full assembled word (including the bit sampled on this edge), done<=1, busy<=0, sel<=0, state<=IDLE.
- Latency:
  - Bit k is sampled at edge E0+(k+1)*SETTLE.
  - Completion edge is E0+8*SETTLE; done is high for exactly the one cycle following it.
  - With SETTLE=1, done is high in the 8th cycle after the start edge.
- data changes only on a completion edge and holds the previous scan's value throughout a scan. Partial results are never visible.
- start while busy=1 is ignored, not queued.
- start=1 during the done cycle (state IDLE) is accepted. The next scan begins, so back-to-back scans have no idle gap beyond that cycle.
- start held continuously high starts a new scan every 8*SETTLE+1 cycles.
- Reset mid-scan: immediate abort, all outputs return to reset values, partial bits discarded, no done pulse.
- sel is a registered output with no glitches. mux_out is assumed stable from SETTLE cycles after sel changes; the mux's combinational delay fits within one cycle.
- SETTLE outside 1..255 is a configuration error. The implementation flags it with an elaboration-time check.
- wait_cnt is 8 bits wide.

Optional Feature:
SCAN_PARITY_EN
- Defined:
  - Adds output port parity (1 bit) = XOR of all 8 bits of data.
  - Registered and updated on the same completion edge as data.
  - Reset value 0.
  - Holds between scans.
- Not defined: port parity is absent; no parity logic is synthesized.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> sel=0, data=8'h00, busy=0, done=0 immediately (asynchronous); parity=0 if enabled.
- Single scan, SETTLE=1, bench mux model with inputs = 8'hA5, start pulse at edge E0:
  - sel steps 0..7 on edges E0..E0+7.
  - busy high for 8 cycles.
  - done one cycle after edge E0+8.
  - data=8'hA5; parity=0 if enabled.
- SETTLE=3, inputs=8'h3C: each sel value held 3 cycles, completion at E0+24, data=8'h3C; parity=0 if enabled.
- Inputs=8'h01, start pulses at E0+2 and E0+5 while busy: no effect, single done pulse, data=8'h01; parity=1 if enabled.
- Back-to-back, SETTLE=1:
  - Inputs=8'hFF for scan 1; start held high.
  - Change inputs to 8'h0F after first done.
  - Second scan starts in the done cycle.
  - data=8'hFF then 8'h0F.
  - Exactly 9 cycles between done pulses.
- Reset mid-scan:
  - Inputs=8'h5A; assert rst at E0+4 (sel=4).
  - All outputs reset, no done pulse, data=8'h00.
  - New start then yields data=8'h5A.
